// File: rtl/hub75_line_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub75_line_shifter_pkg
// Description : Shared definitions for the HUB75 line shifter: the pixel
//               field layout of a framebuffer word, the line FSM state
//               encoding and the default number of row-pairs.
// Revision    : 1.0 - initial release
// ============================================================================
package hub75_line_shifter_pkg;

    // One 12-bit pixel: [11:8] R, [7:4] G, [3:0] B.
    localparam int PIX_W   = 12;
    localparam int R_MSB   = 11;
    localparam int R_LSB   = 8;
    localparam int G_MSB   = 7;
    localparam int G_LSB   = 4;
    localparam int B_MSB   = 3;
    localparam int B_LSB   = 0;

    // A framebuffer word holds the top pixel (row r) in the upper half and
    // the bottom pixel (row r + rows) in the lower half.
    localparam int TOP_MSB = 2*PIX_W-1;
    localparam int TOP_LSB = PIX_W;
    localparam int BOT_MSB = PIX_W-1;
    localparam int BOT_LSB = 0;

    // Row-pairs of the default 48-row panel.
    localparam int ROWS    = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        LO    = 3'd3,
        HI    = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_pwm_compare.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pwm_compare
// Description : Combinational PWM slice of one row-pair word. Each colour
//               channel lights when its 4-bit value is strictly greater than
//               the threshold, so threshold 15 is always dark and a zero
//               channel is never lit.
// Ports       : i_word [23:0] - {top pixel, bottom pixel}
//               i_pwm  [3:0]  - PWM threshold
//               o_rgb  [5:0]  - {b1,g1,r1,b0,g0,r0}
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_pwm_compare
    import hub75_line_shifter_pkg::*;
(
    input  logic [2*PIX_W-1:0] i_word,
    input  logic [3:0]         i_pwm,
    output logic [5:0]         o_rgb
);

    logic [PIX_W-1:0] w_top;
    logic [PIX_W-1:0] w_bot;

    assign w_top = i_word[TOP_MSB:TOP_LSB];
    assign w_bot = i_word[BOT_MSB:BOT_LSB];

    assign o_rgb[0] = (w_top[R_MSB:R_LSB] > i_pwm);
    assign o_rgb[1] = (w_top[G_MSB:G_LSB] > i_pwm);
    assign o_rgb[2] = (w_top[B_MSB:B_LSB] > i_pwm);
    assign o_rgb[3] = (w_bot[R_MSB:R_LSB] > i_pwm);
    assign o_rgb[4] = (w_bot[G_MSB:G_LSB] > i_pwm);
    assign o_rgb[5] = (w_bot[B_MSB:B_LSB] > i_pwm);

endmodule
`default_nettype wire

// File: rtl/hub75_line_shifter.sv
`default_nettype none
// ============================================================================
// Module      : hub75_line_shifter
// Description : On a line request, reads one row-pair from framebuffer port B,
//               thresholds every channel against the PWM value and shifts the
//               6-bit pattern out with a generated shift clock, then pulses
//               done_out for one cycle.
// Ports       : i_clk, i_rst      - clock, synchronous active-high reset
//               begin_in/addr/pwm - line request, row-pair index, threshold
//               done_out, busy    - line status to the matrix controller
//               addr_b/re_b       - framebuffer read request (1-cycle latency)
//               data_out_b        - framebuffer read data
//               rgb_en, rgb       - panel shift clock and colour data
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_line_shifter
    import hub75_line_shifter_pkg::*;
#(
    parameter int WIDTH   = 96,
    parameter int HEIGHT  = 2*ROWS,
    parameter int BPP     = 12,
    parameter int CHAINED = 1,
    parameter int ADDR_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              begin_in,
    input  logic [4:0]        addr,
    input  logic [3:0]        pwm,
    output logic              done_out,
    output logic              busy,
    output logic [ADDR_W-1:0] addr_b,
    output logic              re_b,
    input  logic [2*BPP-1:0]  data_out_b,
    output logic              rgb_en,
    output logic [5:0]        rgb
);

    localparam int c_w     = WIDTH*CHAINED;
    localparam int c_rows  = HEIGHT/2;
    localparam int c_col_w = (c_w > 1) ? $clog2(c_w) : 1;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(c_w-1);

    generate
        if (c_rows*c_w > (1 << ADDR_W)) begin : g_addr_check
            $error("hub75_line_shifter: framebuffer does not fit in ADDR_W bits");
        end
        if (BPP != PIX_W) begin : g_bpp_check
            $error("hub75_line_shifter: BPP must be 12 (4 bits per channel)");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_col_w-1:0]  r_col;
    logic                r_row_ok;
    logic [3:0]          r_pwm;
    logic [5:0]          r_rgb;
    logic [ADDR_W-1:0]   r_addr_b;

    logic [c_col_w-1:0]  w_col_inc;
    logic                w_col_last;
    logic                w_next_last;
    logic                w_row_in_range;
    logic [ADDR_W-1:0]   w_base;
    logic [5:0]          w_cmp;
    logic [5:0]          w_pix_rgb;

    pixel_pwm_compare u_cmp (
        .i_word (data_out_b),
        .i_pwm  (r_pwm),
        .o_rgb  (w_cmp)
    );

    assign w_col_inc      = r_col + c_col_w'(1);
    assign w_col_last     = (r_col == c_col_last);
    assign w_next_last    = (w_col_inc == c_col_last);
    assign w_row_in_range = (int'(addr) < c_rows);
    assign w_base         = ADDR_W'(addr) * ADDR_W'(c_w);
    // Out-of-range rows never read memory, so whatever sits on the read bus
    // is masked rather than shown on the panel.
    assign w_pix_rgb      = r_row_ok ? w_cmp : 6'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_row_ok <= 1'b0;
            r_pwm    <= 4'd0;
            r_rgb    <= 6'd0;
            r_addr_b <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (begin_in) begin
                        r_pwm    <= pwm;
                        r_row_ok <= w_row_in_range;
                        r_col    <= '0;
                        // addr_b only moves when a read is about to use it.
                        if (w_row_in_range) begin
                            r_addr_b <= w_base;
                        end
                    end
                end
                LOAD: begin
                    r_rgb <= w_pix_rgb;
                    // Pre-advance the address for the read issued in LO.
                    if (r_row_ok && !w_col_last) begin
                        r_addr_b <= r_addr_b + ADDR_W'(1);
                    end
                end
                HI: begin
                    if (!w_col_last) begin
                        r_col <= w_col_inc;
                        r_rgb <= w_pix_rgb;
                        if (r_row_ok && !w_next_last) begin
                            r_addr_b <= r_addr_b + ADDR_W'(1);
                        end
                    end else begin
                        r_rgb <= 6'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (begin_in) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = LOAD;
            LOAD:    w_state_nxt = LO;
            LO:      w_state_nxt = HI;
            HI:      w_state_nxt = w_col_last ? DONE : LO;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The LO read fetches column col+1, so the last column issues none.
    assign re_b     = r_row_ok && ((r_state == FETCH) ||
                                   ((r_state == LO) && !w_col_last));
    assign addr_b   = r_addr_b;
    assign busy     = (r_state != IDLE);
    assign done_out = (r_state == DONE);
    assign rgb_en   = (r_state == HI);
    assign rgb      = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_hub75_line_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_line_shifter
// Description : Self-checking bench for hub75_line_shifter. A default-size
//               instance and a two-panel chain share one framebuffer model;
//               every line is checked cycle by cycle against expectations
//               computed from the line timing and the channel > pwm rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_line_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        begin1, begin2;
    logic [4:0]  addr_in;
    logic [3:0]  pwm_in;
    bit          sel;

    logic        done1, busy1, re1, en1;
    logic [11:0] addrb1;
    logic [5:0]  rgb1;
    logic [23:0] rd1;
    logic        done2, busy2, re2, en2;
    logic [12:0] addrb2;
    logic [5:0]  rgb2;
    logic [23:0] rd2;

    logic [23:0] mem [0:8191];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_addr [2];

    always #5 clk = ~clk;

    hub75_line_shifter dut (
        .i_clk(clk), .i_rst(rst), .begin_in(begin1), .addr(addr_in), .pwm(pwm_in),
        .done_out(done1), .busy(busy1), .addr_b(addrb1), .re_b(re1),
        .data_out_b(rd1), .rgb_en(en1), .rgb(rgb1)
    );

    hub75_line_shifter #(.CHAINED(2), .ADDR_W(13)) dut2 (
        .i_clk(clk), .i_rst(rst), .begin_in(begin2), .addr(addr_in), .pwm(pwm_in),
        .done_out(done2), .busy(busy2), .addr_b(addrb2), .re_b(re2),
        .data_out_b(rd2), .rgb_en(en2), .rgb(rgb2)
    );

    always @(posedge clk) begin
        if (re1) rd1 <= mem[addrb1];
        if (re2) rd2 <= mem[addrb2];
    end

    logic        m_done, m_busy, m_re, m_en;
    logic [12:0] m_addr;
    logic [5:0]  m_rgb;
    assign m_done = sel ? done2 : done1;
    assign m_busy = sel ? busy2 : busy1;
    assign m_re   = sel ? re2   : re1;
    assign m_en   = sel ? en2   : en1;
    assign m_addr = sel ? addrb2 : {1'b0, addrb1};
    assign m_rgb  = sel ? rgb2  : rgb1;

    // Channel k lights when its nibble exceeds the threshold; k=0..2 are the
    // top pixel's R,G,B, k=3..5 the bottom pixel's.
    function automatic logic [5:0] model_rgb(input logic [23:0] word, input int p);
        logic [5:0] r;
        int pix, val;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            pix = (k < 3) ? int'(word / 4096) : int'(word % 4096);
            val = (pix / (1 << (8 - 4*(k % 3)))) % 16;
            r[k] = (val > p);
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp, input string info);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d %s", name, act, exp, info);
        end
    endtask

    // Drives a line request in the current cycle (cycle 0) and checks every
    // cycle up to the first idle cycle after done (2W+4). mid_cyc injects a
    // stray begin_in; rst_cyc asserts reset for one cycle.
    task automatic run_line(input int row, input int p, input int mid_cyc,
                            input int rst_cyc, output logic [5:0] first_rgb);
        int w, last, ok_row, idx;
        int ctl_err, rgb_err, en_rises, e_en_rises, re_cnt, e_re_cnt, done_cnt, e_done_cnt;
        bit prev_en, aborted;
        bit e_busy, e_done, e_en, e_re;
        logic [5:0] e_rgb;
        string ctl_msg, rgb_msg;
        w = sel ? 192 : 96;
        last = 2*w + 4;
        ok_row = (row < 24);
        ctl_err = 0; rgb_err = 0; en_rises = 0; e_en_rises = 0;
        re_cnt = 0; e_re_cnt = 0; done_cnt = 0; e_done_cnt = 0;
        prev_en = 1'b0; ctl_msg = ""; rgb_msg = "";
        first_rgb = '0;
        addr_in = 5'(row);
        pwm_in = 4'(p);
        if (sel) begin2 = 1'b1; else begin1 = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            begin1 = 1'b0;
            begin2 = 1'b0;
            rst = 1'b0;
            aborted = (rst_cyc > 0) && (c > rst_cyc);
            e_busy = 0; e_done = 0; e_en = 0; e_re = 0; e_rgb = '0;
            if (!aborted) begin
                e_busy = (c <= 2*w + 3);
                e_done = (c == 2*w + 3);
                if (c >= 3 && c <= 2*w + 2) begin
                    idx = (c - 3) / 2;
                    e_en = ((c - 3) % 2 == 1);
                    if (ok_row) e_rgb = model_rgb(mem[row*w + idx], p);
                    e_re = ok_row && ((c - 3) % 2 == 0) && (idx < w - 1);
                    if (e_re) exp_addr[sel] = row*w + idx + 1;
                end else if (c == 1 && ok_row) begin
                    e_re = 1;
                    exp_addr[sel] = row*w;
                end
            end
            if (c == 3) first_rgb = m_rgb;
            if ({m_busy, m_done, m_en, m_re} != {e_busy, e_done, e_en, e_re} ||
                int'(m_addr) != exp_addr[sel]) begin
                if (ctl_err == 0)
                    ctl_msg = $sformatf("(cycle %0d busy/done/en/re=%b%b%b%b want %b%b%b%b addr_b=%0d want %0d)",
                                        c, m_busy, m_done, m_en, m_re, e_busy, e_done, e_en, e_re,
                                        m_addr, exp_addr[sel]);
                ctl_err++;
            end
            if (m_rgb !== e_rgb) begin
                if (rgb_err == 0)
                    rgb_msg = $sformatf("(cycle %0d rgb=%b want %b)", c, m_rgb, e_rgb);
                rgb_err++;
            end
            if (m_en && !prev_en) en_rises++;
            prev_en = m_en;
            re_cnt += int'(m_re);
            done_cnt += int'(m_done);
            e_en_rises += int'(e_en);
            e_re_cnt += int'(e_re);
            e_done_cnt += int'(e_done);
            if (c == mid_cyc) begin
                if (sel) begin2 = 1'b1; else begin1 = 1'b1;
                addr_in = 5'($urandom_range(0, 23));
                pwm_in = 4'($urandom);
            end
            if (c == rst_cyc) begin
                rst = 1'b1;
                exp_addr[0] = 0;
                exp_addr[1] = 0;
            end
        end
        check($sformatf("ctrl row%0d", row), ctl_err, 0, ctl_msg);
        check($sformatf("rgb row%0d", row), rgb_err, 0, rgb_msg);
        check($sformatf("rgb_en_pulses row%0d", row), en_rises, e_en_rises, "");
        check($sformatf("re_b_count row%0d", row), re_cnt, e_re_cnt, "");
        check($sformatf("done_count row%0d", row), done_cnt, e_done_cnt, "");
    endtask

    typedef struct {
        logic [23:0] word;
        int          pwm;
        logic [5:0]  exp;
    } vec_t;

    vec_t       tbl [6];
    logic [5:0] fr;
    int         rr;

    initial begin
        tbl[0] = '{24'hFFF_FFF, 0,  6'h3F};
        tbl[1] = '{24'h8A3_1F0, 7,  6'b010_011};
        tbl[2] = '{24'h8A3_1F0, 15, 6'b000_000};
        tbl[3] = '{24'h000_000, 0,  6'b000_000};
        tbl[4] = '{24'hF00_F00, 14, 6'b001_001};
        tbl[5] = '{24'h0F0_00F, 14, 6'b100_010};

        for (int i = 0; i < 8192; i++) mem[i] = 24'($urandom);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 96; j++) mem[i*96 + j] = tbl[i].word;

        exp_addr[0] = 0;
        exp_addr[1] = 0;
        rst = 1'b1; begin1 = 1'b0; begin2 = 1'b0; addr_in = '0; pwm_in = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_dut", int'({done1, busy1, re1, en1, rgb1, addrb1} != '0), 0, "");
        check("reset_dut2", int'({done2, busy2, re2, en2, rgb2, addrb2} != '0), 0, "");
        repeat (2) @(negedge clk);

        // Table vectors: rows 0..5 hold one word across the whole row; the
        // lines after the first one start back-to-back in the idle cycle.
        for (int i = 0; i < 6; i++) begin
            run_line(i, tbl[i].pwm, 0, 0, fr);
            check($sformatf("tbl_rgb %0d", i), int'(fr), int'(tbl[i].exp), "");
        end
        repeat (3) @(negedge clk);

        run_line(23, int'($urandom_range(0, 15)), 0, 0, fr);   // addr_b 2208..2303
        run_line(24, 3, 0, 0, fr);                             // out of range
        run_line(31, 0, 0, 0, fr);
        run_line(5, 4, 50, 0, fr);                             // stray begin_in
        run_line(7, 2, 0, 100, fr);                            // reset mid-line
        check("after_reset_idle", int'({done1, busy1, re1, en1, rgb1} != '0), 0, "");
        run_line(8, 5, 0, 0, fr);

        repeat (10) begin
            rr = int'($urandom_range(0, 27));
            run_line(rr, int'($urandom_range(0, 15)), 0, 0, fr);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        sel = 1'b1;
        run_line(23, 0, 0, 0, fr);
        run_line(int'($urandom_range(0, 23)), int'($urandom_range(0, 14)), 0, 0, fr);
        run_line(24, 1, 0, 0, fr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
